// File: rtl/mem_write_checker_if.sv
// Bus between the MIPS data-memory write port, the expected-write table loader
// and the checker's status outputs.
interface mem_write_checker_if #(
  parameter int unsigned N       = 32,
  parameter int unsigned A       = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1000
) ();
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic          memwrite;
  logic [A-1:0]  dataadr;
  logic [N-1:0]  writedata;
  logic          exp_we;
  logic [IW-1:0] exp_idx;
  logic [A-1:0]  exp_addr;
  logic [N-1:0]  exp_data;
  logic [CW-1:0] num_exp;
  logic          start;
  logic          done;
  logic          pass;
  logic [1:0]    fail_code;
  logic [CW-1:0] match_count;
  logic [TW-1:0] cycle_count;
  logic [A-1:0]  bad_addr;
  logic [N-1:0]  bad_data;

  modport slave (
    input  memwrite, dataadr, writedata, exp_we, exp_idx, exp_addr, exp_data,
           num_exp, start,
    output done, pass, fail_code, match_count, cycle_count, bad_addr, bad_data
  );

  modport master (
    output memwrite, dataadr, writedata, exp_we, exp_idx, exp_addr, exp_data,
           num_exp, start,
    input  done, pass, fail_code, match_count, cycle_count, bad_addr, bad_data
  );
endinterface

// File: rtl/mem_write_checker.sv
// Self-checking monitor for the data-memory write port: matches observed writes
// against a table of expected writes (ordered or unordered) with a cycle timeout.
module mem_write_checker #(
  parameter int unsigned N       = 32,
  parameter int unsigned A       = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1000,
  parameter int unsigned ORDERED = 1
) (
  input  logic clk,
  input  logic reset,
  mem_write_checker_if.slave bus
);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t          state_q, state_d;
  logic [A-1:0]    tbl_addr [DEPTH];
  logic [N-1:0]    tbl_data [DEPTH];
  logic [DEPTH-1:0] matched_q, matched_d;
  logic [CW-1:0]   num_q, match_q, match_d;
  logic [TW-1:0]   cyc_q, cyc_d;
  logic            done_q, done_d, pass_q, pass_d;
  logic [1:0]      code_q, code_d;
  logic [A-1:0]    bad_addr_q, bad_addr_d;
  logic [N-1:0]    bad_data_q, bad_data_d;

  logic            hit, mis, conf, last, tmo;
  logic [IW-1:0]   hit_idx;
  logic [CW-1:0]   num_sat;

  assign num_sat = (32'(bus.num_exp) > DEPTH) ? CW'(DEPTH) : bus.num_exp;
  assign last    = (match_q + CW'(hit)) == num_q;
  assign tmo     = (cyc_q + TW'(1)) == TW'(TIMEOUT);

  // Compare the sampled write against the valid table entries.
  always_comb begin
    hit     = 1'b0;
    mis     = 1'b0;
    conf    = 1'b0;
    hit_idx = '0;
    if (bus.memwrite) begin
      if (ORDERED != 0) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (CW'(i) == match_q && CW'(i) < num_q && bus.dataadr == tbl_addr[i]) begin
            if (bus.writedata == tbl_data[i]) begin
              hit     = 1'b1;
              hit_idx = IW'(i);
            end else begin
              mis = 1'b1;
            end
          end
        end
      end else begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (CW'(i) < num_q && bus.dataadr == tbl_addr[i]) begin
            if (!matched_q[i]) begin
              if (bus.writedata == tbl_data[i]) begin
                if (!hit) begin
                  hit     = 1'b1;
                  hit_idx = IW'(i);
                end
              end else begin
                mis = 1'b1;
              end
            end else if (bus.writedata != tbl_data[i]) begin
              conf = 1'b1;
            end
          end
        end
        // An exact match on an unmatched entry wins over any partial hits.
        if (hit) begin
          mis  = 1'b0;
          conf = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (mis || conf) state_d = S_FAIL;
        else if (last)   state_d = S_PASS;
        else if (tmo)    state_d = S_FAIL;
      end
      default: if (bus.start) state_d = S_RUN;
    endcase
  end

  always_comb begin
    matched_d  = matched_q;
    match_d    = match_q;
    cyc_d      = cyc_q;
    done_d     = done_q;
    pass_d     = pass_q;
    code_d     = code_q;
    bad_addr_d = bad_addr_q;
    bad_data_d = bad_data_q;
    case (state_q)
      S_RUN: begin
        cyc_d = cyc_q + TW'(1);
        if (hit) begin
          match_d            = match_q + CW'(1);
          matched_d[hit_idx] = 1'b1;
        end
        if (mis || conf) begin
          done_d     = 1'b1;
          code_d     = mis ? 2'b01 : 2'b11;
          bad_addr_d = bus.dataadr;
          bad_data_d = bus.writedata;
        end else if (last) begin
          done_d = 1'b1;
          pass_d = 1'b1;
        end else if (tmo) begin
          done_d = 1'b1;
          code_d = 2'b10;
        end
      end
      default: begin
        if (bus.start) begin
          matched_d  = '0;
          match_d    = '0;
          cyc_d      = '0;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          code_d     = 2'b00;
          bad_addr_d = '0;
          bad_data_d = '0;
        end
      end
    endcase
  end

  // Status registers, latched entry count and the expected-write table.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      matched_q  <= '0;
      match_q    <= '0;
      cyc_q      <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      code_q     <= 2'b00;
      bad_addr_q <= '0;
      bad_data_q <= '0;
      num_q      <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        tbl_addr[i] <= '0;
        tbl_data[i] <= '0;
      end
    end else begin
      matched_q  <= matched_d;
      match_q    <= match_d;
      cyc_q      <= cyc_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      code_q     <= code_d;
      bad_addr_q <= bad_addr_d;
      bad_data_q <= bad_data_d;
      if (state_q != S_RUN && bus.start) num_q <= num_sat;
      if (state_q != S_RUN && bus.exp_we && 32'(bus.exp_idx) < DEPTH) begin
        tbl_addr[bus.exp_idx] <= bus.exp_addr;
        tbl_data[bus.exp_idx] <= bus.exp_data;
      end
    end
  end

  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.fail_code   = code_q;
  assign bus.match_count = match_q;
  assign bus.cycle_count = cyc_q;
  assign bus.bad_addr    = bad_addr_q;
  assign bus.bad_data    = bad_data_q;
endmodule

// File: tb/tb_mem_write_checker.sv
// Scoreboard bench: stimulus queues the expected final status; a monitor pops
// and compares it whenever a checker raises done.
module tb_mem_write_checker;
  typedef struct packed {
    logic        done;
    logic        pass;
    logic [1:0]  code;
    logic [2:0]  mc;
    logic [4:0]  cc;
    logic [31:0] ba;
    logic [31:0] bd;
  } resp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  resp_t q_o[$];
  resp_t q_u[$];
  logic prev_o = 1'b0;
  logic prev_u = 1'b0;

  always #5 clk = ~clk;

  mem_write_checker_if #(.N(32), .A(32), .DEPTH(4), .TIMEOUT(20)) bo ();
  mem_write_checker_if #(.N(32), .A(32), .DEPTH(4), .TIMEOUT(20)) bu ();

  mem_write_checker #(.N(32), .A(32), .DEPTH(4), .TIMEOUT(20), .ORDERED(1)) u_ord (
    .clk(clk), .reset(reset), .bus(bo));
  mem_write_checker #(.N(32), .A(32), .DEPTH(4), .TIMEOUT(20), .ORDERED(0)) u_unord (
    .clk(clk), .reset(reset), .bus(bu));

  function automatic resp_t snap(input bit u);
    resp_t r;
    if (u) r = {bu.done, bu.pass, bu.fail_code, bu.match_count, bu.cycle_count, bu.bad_addr, bu.bad_data};
    else   r = {bo.done, bo.pass, bo.fail_code, bo.match_count, bo.cycle_count, bo.bad_addr, bo.bad_data};
    return r;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic cmp_resp(input string tag, input resp_t act, input resp_t req);
    cmp({tag, ".done"},        32'(act.done), 32'(req.done));
    cmp({tag, ".pass"},        32'(act.pass), 32'(req.pass));
    cmp({tag, ".fail_code"},   32'(act.code), 32'(req.code));
    cmp({tag, ".match_count"}, 32'(act.mc),   32'(req.mc));
    cmp({tag, ".cycle_count"}, 32'(act.cc),   32'(req.cc));
    cmp({tag, ".bad_addr"},    act.ba,        req.ba);
    cmp({tag, ".bad_data"},    act.bd,        req.bd);
  endtask

  // Monitor: a rising done on either checker consumes one queued expectation.
  always @(negedge clk) begin
    if (bo.done && !prev_o) begin
      if (q_o.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL ord.unexpected_done: got done=1 expected no result");
      end else cmp_resp("ord", snap(1'b0), q_o.pop_front());
    end
    if (bu.done && !prev_u) begin
      if (q_u.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unord.unexpected_done: got done=1 expected no result");
      end else cmp_resp("unord", snap(1'b1), q_u.pop_front());
    end
    prev_o = bo.done;
    prev_u = bu.done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_resp(input bit u, input bit p, input logic [1:0] code,
                             input int mc, input int cc, input logic [31:0] ba,
                             input logic [31:0] bd);
    resp_t r;
    r = {1'b1, p, code, 3'(mc), 5'(cc), ba, bd};
    if (u) q_u.push_back(r);
    else   q_o.push_back(r);
  endtask

  task automatic drv_load(input bit u, input int idx, input logic [31:0] a, input logic [31:0] d);
    if (u) begin bu.exp_we = 1'b1; bu.exp_idx = 2'(idx); bu.exp_addr = a; bu.exp_data = d; end
    else   begin bo.exp_we = 1'b1; bo.exp_idx = 2'(idx); bo.exp_addr = a; bo.exp_data = d; end
    tick();
    bu.exp_we = 1'b0;
    bo.exp_we = 1'b0;
  endtask

  task automatic drv_write(input bit u, input logic [31:0] a, input logic [31:0] d);
    if (u) begin bu.memwrite = 1'b1; bu.dataadr = a; bu.writedata = d; end
    else   begin bo.memwrite = 1'b1; bo.dataadr = a; bo.writedata = d; end
    tick();
    bu.memwrite = 1'b0;
    bo.memwrite = 1'b0;
  endtask

  task automatic drv_start(input bit u, input int num);
    if (u) begin bu.num_exp = 3'(num); bu.start = 1'b1; end
    else   begin bo.num_exp = 3'(num); bo.start = 1'b1; end
    tick();
    bu.start = 1'b0;
    bo.start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while ((q_o.size() != 0 || q_u.size() != 0) && n < max_cycles) begin
      tick();
      n++;
    end
    if (q_o.size() != 0 || q_u.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", q_o.size() + q_u.size());
      q_o.delete();
      q_u.delete();
    end
  endtask

  task automatic check_zero(input string tag, input bit u);
    resp_t z;
    z = '0;
    cmp_resp(tag, snap(u), z);
  endtask

  initial begin
    bo.memwrite = 1'b0; bo.dataadr = '0; bo.writedata = '0; bo.exp_we = 1'b0;
    bo.exp_idx = '0; bo.exp_addr = '0; bo.exp_data = '0; bo.num_exp = '0; bo.start = 1'b0;
    bu.memwrite = 1'b0; bu.dataadr = '0; bu.writedata = '0; bu.exp_we = 1'b0;
    bu.exp_idx = '0; bu.exp_addr = '0; bu.exp_data = '0; bu.num_exp = '0; bu.start = 1'b0;
    idle(2);
    check_zero("rst_ord", 1'b0);
    check_zero("rst_unord", 1'b1);
    reset = 1'b1;
    idle(1);

    // Ordered basic match.
    drv_load(0, 0, 32'd84, 32'h96);
    expect_resp(0, 1, 2'b00, 1, 1, 0, 0);
    drv_start(0, 1);
    drv_write(0, 32'd84, 32'h96);
    wait_drain(10);

    // Ordered: out-of-order write ignored; start during RUN ignored.
    drv_load(0, 0, 32'd80, 32'h7);
    drv_load(0, 1, 32'd84, 32'h96);
    expect_resp(0, 1, 2'b00, 2, 3, 0, 0);
    drv_start(0, 2);
    bo.start = 1'b1;
    drv_write(0, 32'd84, 32'h96);
    bo.start = 1'b0;
    drv_write(0, 32'd80, 32'h7);
    drv_write(0, 32'd84, 32'h96);
    wait_drain(10);

    // Table load ignored while running.
    drv_load(0, 0, 32'd84, 32'h96);
    expect_resp(0, 1, 2'b00, 1, 2, 0, 0);
    drv_start(0, 1);
    drv_load(0, 0, 32'd84, 32'h55);
    drv_write(0, 32'd84, 32'h96);
    wait_drain(10);

    // Data mismatch.
    expect_resp(0, 0, 2'b01, 0, 1, 32'd84, 32'h95);
    drv_start(0, 1);
    drv_write(0, 32'd84, 32'h95);
    wait_drain(10);

    // Timeout with no writes.
    expect_resp(0, 0, 2'b10, 0, 20, 0, 0);
    drv_start(0, 1);
    wait_drain(40);

    // Final match in the timeout cycle passes.
    expect_resp(0, 1, 2'b00, 1, 20, 0, 0);
    drv_start(0, 1);
    idle(19);
    drv_write(0, 32'd84, 32'h96);
    wait_drain(10);

    // Mismatch in the timeout cycle reports data mismatch.
    expect_resp(0, 0, 2'b01, 0, 20, 32'd84, 32'h95);
    drv_start(0, 1);
    idle(19);
    drv_write(0, 32'd84, 32'h95);
    wait_drain(10);

    // Zero expected writes passes on the first RUN edge.
    expect_resp(0, 1, 2'b00, 0, 1, 0, 0);
    drv_start(0, 0);
    wait_drain(10);

    // Reset mid-run clears everything immediately, then a rerun passes.
    drv_start(0, 1);
    idle(3);
    reset = 1'b0;
    #1;
    check_zero("midrst_ord", 1'b0);
    check_zero("midrst_unord", 1'b1);
    reset = 1'b1;
    drv_load(0, 0, 32'd84, 32'h96);
    expect_resp(0, 1, 2'b00, 1, 1, 0, 0);
    drv_start(0, 1);
    drv_write(0, 32'd84, 32'h96);
    wait_drain(10);

    // Unordered: rewrite of a matched address with new data.
    drv_load(1, 0, 32'd80, 32'h1);
    drv_load(1, 1, 32'd84, 32'h2);
    expect_resp(1, 0, 2'b11, 1, 2, 32'd84, 32'h3);
    drv_start(1, 2);
    drv_write(1, 32'd84, 32'h2);
    drv_write(1, 32'd84, 32'h3);
    wait_drain(10);

    // Unordered any-order completion; num_exp=7 saturates to 4.
    drv_load(1, 2, 32'd88, 32'h3);
    drv_load(1, 3, 32'd92, 32'h4);
    expect_resp(1, 1, 2'b00, 4, 5, 0, 0);
    drv_start(1, 7);
    drv_write(1, 32'd92, 32'h4);
    drv_write(1, 32'd84, 32'h2);
    drv_write(1, 32'd84, 32'h2);
    drv_write(1, 32'd80, 32'h1);
    drv_write(1, 32'd88, 32'h3);
    wait_drain(10);

    // Unordered data mismatch on an unmatched entry.
    expect_resp(1, 0, 2'b01, 0, 1, 32'd88, 32'h5);
    drv_start(1, 4);
    drv_write(1, 32'd88, 32'h5);
    wait_drain(10);

    // Duplicate entries: each write matches exactly one, lowest index first.
    drv_load(1, 0, 32'd80, 32'h1);
    drv_load(1, 1, 32'd80, 32'h1);
    expect_resp(1, 1, 2'b00, 2, 2, 0, 0);
    drv_start(1, 2);
    drv_write(1, 32'd80, 32'h1);
    drv_write(1, 32'd80, 32'h1);
    wait_drain(10);

    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
- Synthesizable, parametrised self-checking monitor for the single-cycle MIPS computer's data-memory write port (memwrite/dataadr/writedata).
- Generalises the single hard-coded "write X to RAM[addr]" pass check into a table of DEPTH expected writes, with ordered and unordered modes, a cycle timeout and diagnostic outputs.
- Instantiated beside the computer in benches and optionally on FPGA builds, where it drives a status LED.

Parameters:
- N, 32, data width of writedata and expected data.
- A, 32, address width of dataadr and expected address.
- DEPTH, 4, number of expected-write entries (1..16).
- TIMEOUT, 1000, cycles in RUN before declaring failure (>=1).
- ORDERED, 1, 1 = expected writes must occur in table order; 0 = any order.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- reset, input, 1, asynchronous, active-low; 0 forces reset state immediately.
- memwrite, input, 1, data-memory write strobe from the computer.
- dataadr, input, A, write address.
- writedata, input, N, write data.
- exp_we, input, 1, load strobe for one expected entry.
- exp_idx, input, clog2(DEPTH), entry index to load.
- exp_addr, input, A, expected address for the loaded entry.
- exp_data, input, N, expected data for the loaded entry.
- num_exp, input, clog2(DEPTH+1), count of valid entries; sampled on start.
- start, input, 1, single-cycle pulse that begins checking.
- done, output, 1, high in PASS or FAIL.
- pass, output, 1, high only in PASS.
- fail_code, output, 2, 00 none; 01 data mismatch; 10 timeout; 11 conflicting rewrite (unordered mode only).
- match_count, output, clog2(DEPTH+1), number of entries matched so far.
- cycle_count, output, clog2(TIMEOUT+1), cycles spent in RUN.
- bad_addr, output, A, address of the failing write; 0 otherwise.
- bad_data, output, N, data of the failing write; 0 otherwise.

Behaviour:
- Reset (reset=0, async):
  - State returns to IDLE.
  - All outputs go to 0.
  - Table contents and matched flags are cleared.
  - Reset asserted mid-RUN aborts the run; no PASS or FAIL is reported.
- States and transitions:
  - IDLE -> RUN on start.
  - RUN -> PASS when match_count reaches the latched num_exp.
  - RUN -> FAIL on mismatch, on conflicting rewrite, or when cycle_count reaches TIMEOUT.
  - PASS or FAIL -> RUN on start: clears matched flags, match_count, cycle_count, bad_addr, bad_data and fail_code; table contents are kept.
- Loading:
  - exp_we writes entry exp_idx in IDLE, PASS or FAIL.
  - exp_we is ignored in RUN.
  - start is ignored in RUN.
- num_exp handling:
  - num_exp is latched on start; values above DEPTH saturate to DEPTH.
  - num_exp=0: RUN -> PASS on the first edge after start.
- Sampling and counting:
  - memwrite is sampled on each rising edge in RUN.
  - Compare results and state update are registered: done/pass become visible one cycle after the deciding write is sampled.
  - cycle_count increments every RUN cycle and freezes in PASS or FAIL.
- Ordered mode, pointer ptr = match_count:
  - dataadr == exp_addr[ptr] and writedata == exp_data[ptr]: ptr increments.
  - dataadr == exp_addr[ptr] and data differs: FAIL code 01.
  - Any other address: ignored, including earlier matched addresses.
- Unordered mode (compare against all unmatched valid entries in parallel):
  - Address and data match: set that entry's matched flag; match_count increments by exactly 1.
  - If two unmatched entries share an address and data, the lowest index is matched.
  - Address matches an unmatched entry but data differs: FAIL code 01.
  - Address equals an already-matched entry with different data: FAIL code 11.
  - Same address and data as an already-matched entry: ignored.
- Failure capture: bad_addr/bad_data capture the failing write; both stay 0 on timeout.
- Simultaneous events:
  - The final match and the timeout in the same cycle give PASS.
  - A mismatch in the timeout cycle gives code 01.
- Widths: comparisons use full A and N bits; counters never wrap because they freeze at their terminal values.

Test Plan:
- Ordered basic: load entry0 = (84, 0x96), num_exp=1, start, drive memwrite with adr 84, data 0x96 -> pass=1, done=1, match_count=1, fail_code=00 one cycle later.
- Ordered out-of-order: entries (80, 0x7), (84, 0x96); write 84/0x96 then 80/0x7 then 84/0x96 -> first write ignored, PASS after the third write, match_count=2.
- Mismatch: entry (84, 0x96); write 84/0x95 -> FAIL, fail_code=01, bad_addr=84, bad_data=0x95.
- Timeout: TIMEOUT=20, entry (84, 0x96), no writes -> FAIL, fail_code=10, cycle_count=20, bad_addr=0.
- Unordered conflict (ORDERED=0): entries (80, 1), (84, 2), num_exp=2; write 84/2 then 84/3 -> match_count=1, FAIL code 11, bad_data=3.
- Reset mid-run and rerun: during RUN pulse reset=0 -> all outputs 0 immediately, state IDLE; reload, start and complete -> PASS. Also num_exp=0 start -> PASS next edge with cycle_count=1.
